// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl: button sync/debounce, left/right arbitration and
// rate-controlled paddle stepping with hold acceleration.
module paddle_input_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_PERIOD     = 100000,
  parameter int FAST_PERIOD     = 25000,
  parameter int FAST_AFTER      = 16,
  parameter int PADDLE_INIT     = 320,
  parameter int PADDLE_MIN      = 86,
  parameter int PADDLE_MAX      = 553
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       leftbutton,
  input  logic       rightbutton,
  input  logic       freeze,
  output logic [9:0] paddlex,
  output logic       left_db,
  output logic       right_db,
  output logic       step,
  output logic       at_limit
);

  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW =
    (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam int NW = $clog2(FAST_AFTER + 1) > 0 ?
    $clog2(FAST_AFTER + 1) : 1;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SP_LAST = SW'(STEP_PERIOD - 1);
  localparam logic [SW-1:0] FP_LAST = SW'(FAST_PERIOD - 1);
  localparam logic [NW-1:0] N_SAT   = NW'(FAST_AFTER);
  localparam logic [9:0]    P_INIT  = 10'(PADDLE_INIT);
  localparam logic [10:0]   P_MIN   = 11'(PADDLE_MIN);
  localparam logic [10:0]   P_MAX   = 11'(PADDLE_MAX);
  localparam logic INIT_LIM =
    (PADDLE_INIT == PADDLE_MIN) || (PADDLE_INIT == PADDLE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    MOVE_L,
    MOVE_R,
    BLOCKED
  } state_t;

  logic [SYNC_STAGES-1:0] lsync;
  logic [SYNC_STAGES-1:0] rsync;
  logic [1:0]             sync_s;
  logic [1:0]             db;
  logic [1:0][DW-1:0]     dcnt;

  state_t state;
  state_t state_nx;

  logic          moving;
  logic          fresh;
  logic          fast;
  logic          fire;
  logic [SW-1:0] scnt;
  logic [NW-1:0] nsteps;
  logic [10:0]   px_wide;
  logic [10:0]   px_cand;

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      lsync <= '0;
      rsync <= '0;
    end else begin
      lsync <= {lsync[SYNC_STAGES-2:0], leftbutton};
      rsync <= {rsync[SYNC_STAGES-2:0], rightbutton};
    end
  end

  assign sync_s = {rsync[SYNC_STAGES-1], lsync[SYNC_STAGES-1]};

  // Index 0 is the left button, index 1 the right.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      db   <= '0;
      dcnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_s[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_LAST) begin
          db[i]   <= sync_s[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  assign left_db  = db[0];
  assign right_db = db[1];

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!freeze && left_db && !right_db)
          state_nx = MOVE_L;
        else if (!freeze && right_db && !left_db)
          state_nx = MOVE_R;
      end
      MOVE_L: begin
        if (!left_db || freeze) state_nx = IDLE;
      end
      MOVE_R: begin
        if (!right_db || freeze) state_nx = IDLE;
      end
      BLOCKED: begin
        if (!left_db || !right_db) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (left_db && right_db) state_nx = BLOCKED;
  end

  assign moving = (state == MOVE_L) || (state == MOVE_R);
  assign fast   = (nsteps == N_SAT);

  // fresh marks the first cycle of a move so the first step is immediate.
  assign fire = moving && !freeze &&
    (fresh || scnt == (fast ? FP_LAST : SP_LAST));

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      fresh  <= 1'b1;
      scnt   <= '0;
      nsteps <= '0;
    end else begin
      fresh <= !moving;
      if (!moving) begin
        scnt   <= '0;
        nsteps <= '0;
      end else if (fire) begin
        scnt <= '0;
        if (!fast) nsteps <= nsteps + NW'(1);
      end else begin
        scnt <= scnt + SW'(1);
      end
    end
  end

  assign px_wide = {1'b0, paddlex};

  always_comb begin
    px_cand = px_wide;
    if (state == MOVE_L)
      px_cand = (px_wide > P_MIN) ? px_wide - 11'd1 : P_MIN;
    else if (state == MOVE_R)
      px_cand = (px_wide < P_MAX) ? px_wide + 11'd1 : P_MAX;
  end

  // A step at a limit leaves paddlex alone and raises no pulse.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      paddlex  <= P_INIT;
      step     <= 1'b0;
      at_limit <= INIT_LIM;
    end else begin
      step <= 1'b0;
      if (fire && px_cand != px_wide) begin
        paddlex  <= px_cand[9:0];
        step     <= 1'b1;
        at_limit <= (px_cand == P_MIN) || (px_cand == P_MAX);
      end
    end
  end

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// tb_paddle_input_ctrl: directed stimulus, cycle model compare plus
// hand-computed checkpoints for the paddle input controller.
module tb_paddle_input_ctrl;

  localparam int SS    = 2;
  localparam int DB    = 8;
  localparam int SP    = 10;
  localparam int FP    = 4;
  localparam int FA    = 3;
  localparam int PINIT = 320;
  localparam int PMIN  = 86;
  localparam int PMAX  = 553;

  localparam int M_IDLE = 0;
  localparam int M_L    = 1;
  localparam int M_R    = 2;
  localparam int M_BLK  = 3;

  logic       clk = 1'b0;
  logic       resetb = 1'b1;
  logic       leftbutton = 1'b0;
  logic       rightbutton = 1'b0;
  logic       freeze = 1'b0;
  logic [9:0] paddlex;
  logic       left_db;
  logic       right_db;
  logic       step;
  logic       at_limit;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  paddle_input_ctrl #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .STEP_PERIOD    (SP),
    .FAST_PERIOD    (FP),
    .FAST_AFTER     (FA),
    .PADDLE_INIT    (PINIT),
    .PADDLE_MIN     (PMIN),
    .PADDLE_MAX     (PMAX)
  ) dut (
    .clk        (clk),
    .resetb     (resetb),
    .leftbutton (leftbutton),
    .rightbutton(rightbutton),
    .freeze     (freeze),
    .paddlex    (paddlex),
    .left_db    (left_db),
    .right_db   (right_db),
    .step       (step),
    .at_limit   (at_limit)
  );

  initial forever #5 clk = ~clk;

  // Model: a debounced level flips once the raw samples taken
  // SS..SS+DB-1 edges ago all disagree with it; steps fire at
  // absolute cycle numbers scheduled from move entry.
  int m_px;
  bit m_ldb;
  bit m_rdb;
  bit m_step;
  bit m_lim;
  int m_mode;
  int m_nmode;
  int m_np;
  bit m_fire;
  int cyc = 0;
  int next_fire;
  int nfires;
  bit lq[$];
  bit rq[$];

  function automatic bit settled(input bit q[$], input bit lvl);
    if (q.size() < SS + DB) return 1'b0;
    for (int i = 0; i < DB; i++)
      if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit is_move(input int md);
    return (md == M_L) || (md == M_R);
  endfunction

  always @(posedge clk or posedge resetb) begin
    if (resetb) begin
      m_px      = PINIT;
      m_ldb     = 1'b0;
      m_rdb     = 1'b0;
      m_step    = 1'b0;
      m_lim     = 1'b0;
      m_mode    = M_IDLE;
      nfires    = 0;
      next_fire = -1;
      lq.delete();
      rq.delete();
    end else begin
      m_fire = is_move(m_mode) && !freeze && (cyc == next_fire);
      m_step = 1'b0;
      if (m_fire) begin
        if (m_mode == M_L)
          m_np = (m_px - 1 < PMIN) ? PMIN : m_px - 1;
        else
          m_np = (m_px + 1 > PMAX) ? PMAX : m_px + 1;
        if (nfires < FA) nfires++;
        next_fire = cyc + ((nfires >= FA) ? FP : SP);
        if (m_np != m_px) begin
          m_px   = m_np;
          m_step = 1'b1;
        end
      end
      m_lim = (m_px == PMIN) || (m_px == PMAX);
      if (m_ldb && m_rdb) m_nmode = M_BLK;
      else if (m_mode == M_IDLE)
        m_nmode = freeze ? M_IDLE :
                  m_ldb ? M_L : m_rdb ? M_R : M_IDLE;
      else if (m_mode == M_L)
        m_nmode = (m_ldb && !freeze) ? M_L : M_IDLE;
      else if (m_mode == M_R)
        m_nmode = (m_rdb && !freeze) ? M_R : M_IDLE;
      else
        m_nmode = M_IDLE;
      if (is_move(m_nmode) && !is_move(m_mode)) begin
        next_fire = cyc + 1;
        nfires    = 0;
      end
      m_mode = m_nmode;
      lq.push_back(leftbutton);
      rq.push_back(rightbutton);
      if (lq.size() > SS + DB) void'(lq.pop_front());
      if (rq.size() > SS + DB) void'(rq.pop_front());
      if (settled(lq, m_ldb)) m_ldb = !m_ldb;
      if (settled(rq, m_rdb)) m_rdb = !m_rdb;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en && !resetb) begin
      checks++;
      if (paddlex !== 10'(m_px) || left_db !== m_ldb ||
          right_db !== m_rdb || step !== m_step ||
          at_limit !== m_lim) begin
        failures++;
        $display("FAIL model t=%0t px=%0d/%0d ldb=%0b/%0b rdb=%0b/%0b step=%0b/%0b lim=%0b/%0b",
          $time, paddlex, m_px, left_db, m_ldb, right_db, m_rdb,
          step, m_step, at_limit, m_lim);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetb = 1'b1;
    tick(3);
    resetb = 1'b0;
  endtask

  initial begin
    tick(3);
    resetb = 1'b0;
    chk_en = 1'b1;
    chk("rst_px", paddlex, 320);
    chk("rst_ldb", left_db, 0);
    chk("rst_rdb", right_db, 0);
    chk("rst_step", step, 0);
    chk("rst_lim", at_limit, 0);

    // Hold left: debounce latency, slow then fast stepping.
    tick(2);
    leftbutton = 1'b1;
    tick(9);  chk("ldb_early", left_db, 0);
    tick(1);  chk("ldb_rise", left_db, 1);
    tick(1);  chk("px_entry", paddlex, 320);
    tick(1);  chk("px_1st", paddlex, 319);
    chk("step_1st", step, 1);
    tick(9);  chk("px_gap", paddlex, 319);
    chk("step_gap", step, 0);
    tick(1);  chk("px_2nd", paddlex, 318);
    tick(10); chk("px_3rd", paddlex, 317);
    tick(4);  chk("px_fast1", paddlex, 316);
    chk("step_fast1", step, 1);
    tick(3);  chk("step_fgap", step, 0);
    tick(1);  chk("px_fast2", paddlex, 315);
    leftbutton = 1'b0;
    tick(20);

    // Glitches shorter than the debounce window.
    do_reset();
    tick(2);
    leftbutton = 1'b1;
    tick(5);
    leftbutton = 1'b0;
    tick(20);
    chk("glitch_ldb", left_db, 0);
    for (int i = 0; i < 4; i++) begin
      leftbutton = 1'b1;
      tick(7);
      leftbutton = 1'b0;
      tick(7);
    end
    tick(20);
    chk("chatter_ldb", left_db, 0);
    chk("chatter_px", paddlex, 320);

    // Both held: blocked, then release right.
    leftbutton  = 1'b1;
    rightbutton = 1'b1;
    tick(200);
    chk("blk_px", paddlex, 320);
    chk("blk_rdb", right_db, 1);
    rightbutton = 1'b0;
    tick(12); chk("unblk_wait", paddlex, 320);
    tick(1);  chk("unblk_px", paddlex, 319);
    chk("unblk_step", step, 1);
    leftbutton = 1'b0;
    tick(30);

    // Run right into the upper limit, then step back left.
    do_reset();
    tick(2);
    rightbutton = 1'b1;
    tick(1100);
    chk("max_px", paddlex, 553);
    chk("max_lim", at_limit, 1);
    tick(50);
    chk("max_hold", paddlex, 553);
    chk("max_step", step, 0);
    rightbutton = 1'b0;
    leftbutton  = 1'b1;
    tick(12); chk("rev_wait", paddlex, 553);
    chk("rev_lim0", at_limit, 1);
    tick(1);  chk("rev_px", paddlex, 552);
    chk("rev_lim", at_limit, 0);
    leftbutton = 1'b0;
    tick(30);

    // Async reset during a fast move, then freeze while held.
    do_reset();
    tick(2);
    rightbutton = 1'b1;
    tick(48);
    chk("fast_px", paddlex, 327);
    chk("fast_step", step, 1);
    #2 resetb = 1'b1;
    #1;
    chk("arst_px", paddlex, 320);
    chk("arst_step", step, 0);
    tick(2);
    resetb = 1'b0;
    tick(30);
    chk("frz_pre", paddlex, 322);
    freeze = 1'b1;
    tick(20);
    chk("frz_hold", paddlex, 322);
    freeze = 1'b0;
    tick(1);  chk("frz_wait", paddlex, 322);
    tick(1);  chk("frz_px", paddlex, 323);
    chk("frz_step", step, 1);
    tick(9);  chk("frz_gap", paddlex, 323);
    tick(1);  chk("frz_2nd", paddlex, 324);
    rightbutton = 1'b0;
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
